// File: rtl/if_stage_if.sv
// Instruction-ROM bus between the fetch stage (master) and a combinational IROM (slave).
interface if_stage_if #(
    parameter int unsigned ADDR_W = 14
);
    logic [ADDR_W-1:0] irom_addr;
    logic [31:0]       irom_data;

    modport master (output irom_addr, input  irom_data);
    modport slave  (input  irom_addr, output irom_data);
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the IROM address and presents
// pc / pc+4 / instruction / rd to IF/ID, with saturating debug counters.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ADDR_W   = 14,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    if_stage_if.master        irom,
    output logic [31:0]       pc_o,
    output logic [31:0]       pc4_o,
    output logic [31:0]       inst_o,
    output logic [4:0]        wR_o,
    output logic              valid_o,
    output logic [CNT_W-1:0]  fetch_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic {BOOT, RUN} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, pc_plus4;
    logic        fetch_inc, stall_inc;
    logic [1:0]  unused_pc_lsb;

    // Target alignment bits are discarded; kept only to document that.
    assign unused_pc_lsb = redirect_pc[1:0];

    assign pc_plus4       = pc_q + 32'd4;
    assign pc_o           = pc_q;
    assign pc4_o          = pc_plus4;
    assign irom.irom_addr = pc_q[ADDR_W+1:2];
    assign wR_o           = inst_o[11:7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Redirect outranks both BOOT hold and stall.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_o    = '0;
        valid_o   = 1'b0;
        fetch_inc = 1'b0;
        stall_inc = 1'b0;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                inst_o    = irom.irom_data;
                valid_o   = 1'b1;
                fetch_inc = !stall && !redirect;
                stall_inc = stall && !redirect;
            end
            default: state_d = BOOT;
        endcase
        if (redirect)
            pc_d = {redirect_pc[31:2], 2'b00};
        else if (state_q == RUN && !stall)
            pc_d = pc_plus4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (fetch_inc && fetch_cnt != '1)
                fetch_cnt <= fetch_cnt + 1'b1;
            if (stall_inc && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a 32-bit-counter instance and a 4-bit-counter
// instance share stimulus and are checked against a behavioural fetch model.
module tb_if_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, stall, redirect;
    logic [31:0] redirect_pc;

    logic [31:0] pc_o, pc4_o, inst_o, pc_s, pc4_s, inst_s;
    logic [4:0]  wr_o, wr_s;
    logic        valid_o, valid_s;
    logic [31:0] fetch_cnt, stall_cnt;
    logic [3:0]  fetch_s, stall_s;

    function automatic logic [31:0] rom(input logic [13:0] a);
        return {a, 2'b01, a[6:0], ~a[8:0]};
    endfunction

    if_stage_if #(.ADDR_W(14)) bus ();
    if_stage_if #(.ADDR_W(14)) bus_s ();
    assign bus.irom_data   = rom(bus.irom_addr);
    assign bus_s.irom_data = rom(bus_s.irom_addr);

    if_stage #(.RESET_PC(32'h0), .ADDR_W(14), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .irom(bus), .pc_o(pc_o), .pc4_o(pc4_o),
        .inst_o(inst_o), .wR_o(wr_o), .valid_o(valid_o),
        .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
    );

    if_stage #(.RESET_PC(32'h0), .ADDR_W(14), .CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .irom(bus_s), .pc_o(pc_s), .pc4_o(pc4_s),
        .inst_o(inst_s), .wR_o(wr_s), .valid_o(valid_s),
        .fetch_cnt(fetch_s), .stall_cnt(stall_s)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc, pc4, inst, fetch, stall_c;
        logic [13:0] addr;
        logic [4:0]  wr;
        logic        valid;
        logic [3:0]  fetch4, stall4;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0]     m_pc;
    bit              m_boot;
    longint unsigned m_fetch, m_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sat32(input longint unsigned v);
        return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    function automatic logic [3:0] sat4(input longint unsigned v);
        return (v > 15) ? 4'hF : v[3:0];
    endfunction

    task automatic model_reset();
        m_pc    = 32'h0;
        m_boot  = 1'b1;
        m_fetch = 0;
        m_stall = 0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"},    pc_o,      32'h0);
        chk({tag, "_pc4"},   pc4_o,     32'h4);
        chk({tag, "_inst"},  inst_o,    32'h0);
        chk({tag, "_wr"},    {27'h0, wr_o}, 32'h0);
        chk({tag, "_valid"}, {31'h0, valid_o}, 32'h0);
        chk({tag, "_addr"},  {18'h0, bus.irom_addr}, 32'h0);
        chk({tag, "_fcnt"},  fetch_cnt, 32'h0);
        chk({tag, "_scnt"},  stall_cnt, 32'h0);
        chk({tag, "_fcnt4"}, {28'h0, fetch_s}, 32'h0);
        chk({tag, "_valid4"}, {31'h0, valid_s}, 32'h0);
    endtask

    // Drive one cycle of inputs (called at a negedge), predict, then wait a cycle.
    task automatic step(input bit s, input bit r, input logic [31:0] rp);
        exp_t e;
        stall       = s;
        redirect    = r;
        redirect_pc = rp;
        if (r)
            m_pc = {rp[31:2], 2'b00};
        else if (!m_boot && !s)
            m_pc = m_pc + 32'd4;
        if (!m_boot && !r) begin
            if (s) m_stall++;
            else   m_fetch++;
        end
        m_boot    = 1'b0;
        e.pc      = m_pc;
        e.pc4     = m_pc + 32'd4;
        e.addr    = m_pc[15:2];
        e.inst    = rom(m_pc[15:2]);
        e.wr      = e.inst[11:7];
        e.valid   = 1'b1;
        e.fetch   = sat32(m_fetch);
        e.stall_c = sat32(m_stall);
        e.fetch4  = sat4(m_fetch);
        e.stall4  = sat4(m_stall);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc",     pc_o,      e.pc);
                chk("pc4",    pc4_o,     e.pc4);
                chk("inst",   inst_o,    e.inst);
                chk("wr",     {27'h0, wr_o}, {27'h0, e.wr});
                chk("valid",  {31'h0, valid_o}, {31'h0, e.valid});
                chk("addr",   {18'h0, bus.irom_addr}, {18'h0, e.addr});
                chk("fcnt",   fetch_cnt, e.fetch);
                chk("scnt",   stall_cnt, e.stall_c);
                chk("fcnt4",  {28'h0, fetch_s}, {28'h0, e.fetch4});
                chk("scnt4",  {28'h0, stall_s}, {28'h0, e.stall4});
                chk("pc_s",   pc_s,      e.pc);
            end
        end
    end

    initial begin
        bit          s, r;
        logic [31:0] rp;
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        #2 chk_reset("rst_hold");
        repeat (2) @(negedge clk);

        // T1: boot cycle, then first fetch at RESET_PC
        rst_n = 1'b1;
        #1 chk_reset("boot");
        model_reset();
        step(0, 0, 32'h0);
        step(0, 0, 32'h0);

        // T2: hold at 0x10 for three stalled cycles
        step(0, 1, 32'h10);
        repeat (3) step(1, 0, 32'h0);
        step(0, 0, 32'h0);

        // T3: redirect wins over simultaneous stall, low bits dropped
        step(0, 1, 32'h20);
        step(1, 1, 32'h103);
        step(0, 0, 32'h0);

        // T4: wrap at top of address space
        step(0, 1, 32'hFFFF_FFFC);
        step(0, 0, 32'h0);
        step(0, 0, 32'h0);

        // T5: free-run long enough to saturate the 4-bit counters
        repeat (20) step(0, 0, 32'h0);

        repeat (400) begin
            s  = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 7) == 0);
            rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : $urandom;
            step(s, r, rp);
        end

        // T6: async reset mid-run while stalled at 0x40
        step(0, 1, 32'h40);
        step(1, 0, 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_reset("async_clr");
        @(negedge clk);
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk_reset("reboot");
        model_reset();
        step(1, 1, 32'h80);
        step(0, 0, 32'h0);
        step(1, 0, 32'h0);
        step(0, 0, 32'h0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        chk("drain", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
